// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: synchronizes the raw UART pin, recovers 8N1 frames using
// 16x oversampling with 2-of-3 majority voting, and buffers received bytes in
// a small first-word-fall-through FIFO. Framing errors, line breaks and
// overruns are reported as single-cycle status pulses.
module uart_rx_frontend #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          break_det,
  output logic                          overrun,
  output logic                          rx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;

  // Reject parameter sets the sampling scheme and FIFO pointers cannot handle.
  generate
    if (OVERSAMPLE != 16) begin : g_bad_oversample
      $error("uart_rx_frontend: OVERSAMPLE must be 16");
    end
    if (DIV < 2) begin : g_bad_div
      $error("uart_rx_frontend: CLOCK_FREQ/(BAUD_RATE*16) must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_rx_frontend: FIFO_DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q, rxs;
  logic [1:0]      fill_q;
  logic            armed_q;
  logic [DW-1:0]   div_q;
  logic [3:0]      scnt_q;
  logic            tick, start_edge;
  logic            s7_q, s8_q, s9_q, s_last, maj;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;
  logic            shift_en, stop_eval, push_req, ferr_d, brk_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            pop, full, push_acc;
  logic            frame_err_q, break_det_q, overrun_q;

  assign rxs = sync2_q;

  // Two-flop synchronizer for the asynchronous serial line (idle level on reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
    end
  end

  // Arm start detection once a genuine high level has come through the
  // synchronizer; fill_q masks the reset value of the sync flops so a line
  // held low through reset cannot arm the receiver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      fill_q <= {fill_q[0], 1'b1};
      if (fill_q[1] && rxs) armed_q <= 1'b1;
    end
  end

  assign start_edge = (state_q == ST_IDLE) && armed_q && !rxs;
  assign tick       = (div_q == DW'(DIV - 1));

  // Oversample tick divider and 16-phase sample counter, realigned at the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      scnt_q <= 4'd0;
    end else if (start_edge) begin
      div_q  <= '0;
      scnt_q <= 4'd0;
    end else if (tick) begin
      div_q  <= '0;
      scnt_q <= scnt_q + 4'd1;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Capture the three mid-bit samples used for the majority vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s7_q <= 1'b1;
      s8_q <= 1'b1;
      s9_q <= 1'b1;
    end else if (tick) begin
      if (scnt_q == 4'd7) s7_q <= rxs;
      if (scnt_q == 4'd8) s8_q <= rxs;
      if (scnt_q == 4'd9) s9_q <= rxs;
    end
  end

  // The stop decision is taken on the scnt==9 tick itself, so the third
  // sample comes straight from the line instead of from s9_q.
  assign s_last = (scnt_q == 4'd9) ? rxs : s9_q;
  assign maj    = (s7_q & s8_q) | (s7_q & s_last) | (s8_q & s_last);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_edge) state_d = ST_START;
      ST_START: if (tick && scnt_q == 4'd15) state_d = maj ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tick && scnt_q == 4'd15 && bit_q == 3'd7) state_d = ST_STOP;
      ST_STOP:  if (tick && scnt_q == 4'd9) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: bit shifting and stop-bit outcome strobes.
  always_comb begin
    shift_en  = (state_q == ST_DATA) && tick && (scnt_q == 4'd15);
    stop_eval = (state_q == ST_STOP) && tick && (scnt_q == 4'd9);
    push_req  = stop_eval && maj;
    ferr_d    = stop_eval && !maj;
    brk_d     = ferr_d && (shreg_q == 8'h00);
  end

  // Data shift register (LSB first) and bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
    end else if (state_q == ST_START) begin
      bit_q <= 3'd0;
    end else if (shift_en) begin
      bit_q   <= bit_q + 3'd1;
      shreg_q <= {maj, shreg_q[7:1]};
    end
  end

  assign pop      = rx_valid && rx_ready;
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign push_acc = push_req && (!full || pop);

  // Circular FIFO storage; a pop in the same cycle frees room for a push into a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_acc) begin
        mem_q[wr_ptr_q] <= shreg_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_acc) - CW'(pop);
    end
  end

  // Registered status pulses, aligned with the FIFO write edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
      break_det_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= ferr_d;
      break_det_q <= brk_d;
      overrun_q   <= push_req && !push_acc;
    end
  end

  assign rx_data    = mem_q[rd_ptr_q];
  assign rx_valid   = (count_q != '0);
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_det_q;
  assign overrun    = overrun_q;
  assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: bit-bangs 8N1 frames onto the line,
// records expected bytes in a scoreboard queue and checks them as the FIFO
// hands them out, plus status pulses, overrun handling and reset behaviour.
module tb_uart_rx_frontend;
  localparam int CF  = 1_600_000;
  localparam int BR  = 10_000;
  localparam int FD  = 4;
  localparam int BIT = 160;

  logic       clk;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       break_det;
  logic       overrun;
  logic       rx_busy;
  logic [2:0] fifo_count;

  int tests;
  int fails;
  int valid_cycles;
  int ferr_cnt;
  int brk_cnt;
  int ovr_cnt;
  logic ferr_prev;
  logic ovr_prev;
  logic [7:0] exp_q[$];

  uart_rx_frontend #(
    .CLOCK_FREQ(CF),
    .BAUD_RATE (BR),
    .OVERSAMPLE(16),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .break_det (break_det),
    .overrun   (overrun),
    .rx_busy   (rx_busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk);
    uart_rx = 1'b0;
    wait_clks(bclk);
    check("busy_in_frame", rx_busy, 1);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clks(bclk);
    end
    uart_rx = stop;
    wait_clks(bclk);
    uart_rx = 1'b1;
    $display("[TB] sent frame data=0x%02h stop=%0b bit_clks=%0d", b, stop, bclk);
  endtask

  initial begin
    int v0, f0, b0, o0;
    logic busy_seen;
    clk = 1'b0;
    tests = 0; fails = 0;
    valid_cycles = 0; ferr_cnt = 0; brk_cnt = 0; ovr_cnt = 0;
    ferr_prev = 1'b0; ovr_prev = 1'b0;
    rst_n = 1'b0; uart_rx = 1'b1; rx_ready = 1'b1;

    // Output monitor / scoreboard consumer
    fork
      forever begin
        @(negedge clk);
        if (rx_valid) valid_cycles++;
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (break_det) begin
          brk_cnt++;
          check("break_with_frame_err", frame_err, 1);
        end
        if (ferr_prev) check("frame_err_one_cycle", frame_err, 0);
        if (ovr_prev) check("overrun_one_cycle", overrun, 0);
        if (rx_valid && rx_ready && rst_n) begin
          tests++;
          assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_byte observed=0x%02h expected=none", rx_data);
          end
          if (exp_q.size() != 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("rx_byte", rx_data, e);
            $display("[TB] popped byte 0x%02h expected 0x%02h", rx_data, e);
          end
        end
        ferr_prev = frame_err;
        ovr_prev  = overrun;
      end
    join_none

    // Reset values
    wait_clks(5);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_break_det", break_det, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rx_busy", rx_busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    rst_n = 1'b1;
    wait_clks(20);

    // Single byte
    v0 = valid_cycles; f0 = ferr_cnt; b0 = brk_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, BIT);
    wait_clks(20);
    check("single_valid_cycles", valid_cycles - v0, 1);
    check("single_no_ferr", ferr_cnt - f0, 0);
    check("single_no_brk", brk_cnt - b0, 0);
    check("single_no_ovr", ovr_cnt - o0, 0);
    check("single_busy_low", rx_busy, 0);
    check("single_drained", exp_q.size(), 0);

    // Glitch rejection
    uart_rx = 1'b0;
    wait_clks(40);
    uart_rx = 1'b1;
    wait_clks(300);
    check("glitch_busy_low", rx_busy, 0);
    check("glitch_no_push", fifo_count, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, BIT);
    wait_clks(20);
    check("after_glitch_drained", exp_q.size(), 0);

    // Framing error
    f0 = ferr_cnt; b0 = brk_cnt;
    send_frame(8'h55, 1'b0, BIT);
    wait_clks(400);
    check("ferr_pulse", ferr_cnt - f0, 1);
    check("ferr_no_brk", brk_cnt - b0, 0);
    check("ferr_no_valid", rx_valid, 0);

    // Break
    f0 = ferr_cnt; b0 = brk_cnt;
    send_frame(8'h00, 1'b0, BIT);
    wait_clks(400);
    check("brk_ferr_pulse", ferr_cnt - f0, 1);
    check("brk_pulse", brk_cnt - b0, 1);
    check("brk_no_valid", rx_valid, 0);

    // Overrun
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i <= FD) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, BIT);
    end
    wait_clks(20);
    check("ovr_count_full", fifo_count, 4);
    check("ovr_pulse", ovr_cnt - o0, 1);
    check("ovr_head", rx_data, 8'h01);
    rx_ready = 1'b1;
    wait_clks(10);
    check("ovr_drain_count", fifo_count, 0);
    check("ovr_drain_valid", rx_valid, 0);
    check("ovr_drain_all", exp_q.size(), 0);

    // Back-to-back frames at +2% and -2% baud
    f0 = ferr_cnt;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h80);
    send_frame(8'hFF, 1'b1, 157);
    send_frame(8'h80, 1'b1, 157);
    wait_clks(50);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h80);
    send_frame(8'hFF, 1'b1, 163);
    send_frame(8'h80, 1'b1, 163);
    wait_clks(50);
    check("b2b_no_ferr", ferr_cnt - f0, 0);
    check("b2b_drained", exp_q.size(), 0);

    // Reset mid-frame with a byte sitting in the FIFO
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, BIT);
    wait_clks(20);
    check("pre_rst_count", fifo_count, 1);
    uart_rx = 1'b0;
    wait_clks(BIT);
    uart_rx = 1'b1;
    wait_clks(BIT);
    uart_rx = 1'b0;
    wait_clks(80);
    check("mid_data_busy", rx_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_busy", rx_busy, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_pulses", {frame_err, break_det, overrun}, 0);
    wait_clks(5);
    rst_n = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 3 * BIT; i++) begin
      wait_clks(1);
      if (rx_busy) busy_seen = 1'b1;
    end
    check("low_line_no_start", busy_seen, 0);
    uart_rx = 1'b1;
    wait_clks(50);
    rx_ready = 1'b1;
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, BIT);
    wait_clks(20);
    check("post_rst_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
